// File: rtl/freq_bram_uart_reader_if.sv
// Bus between the frequency-bin BRAM reader and its surroundings: frame trigger,
// BRAM read port, UART line and frame status.
interface freq_bram_uart_reader_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic                  start;
   logic                  ram_rd_en;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_data;
   logic                  tx;
   logic                  busy;
   logic                  done;

   modport master (
      input  start, ram_data,
      output ram_rd_en, ram_addr, tx, busy, done
   );

   modport slave (
      output start, ram_data,
      input  ram_rd_en, ram_addr, tx, busy, done
   );
endinterface

// File: rtl/freq_bram_uart_reader.sv
// Scans FREQ_BINS bin magnitudes out of the BRAM after each SDFT frame and sends them
// as one UART 8N1 packet: HEADER, bins in address order, XOR checksum of the bins.
module freq_bram_uart_reader #(
   parameter int          DATA_WIDTH   = 8,
   parameter int          FREQ_BINS    = 16,
   parameter int          ADDR_WIDTH   = 4,
   parameter int          CLKS_PER_BIT = 104,
   parameter logic [7:0]  HEADER       = 8'hA5
) (
   input  logic                    clk,
   input  logic                    reset_n,
   freq_bram_uart_reader_if.master bus
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0]     LAST_BAUD = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(FREQ_BINS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HEADER,
      ST_FETCH,
      ST_WAIT_RD,
      ST_SEND,
      ST_CHECKSUM,
      ST_DONE
   } state_t;

   state_t                state, state_n;
   logic [BAUD_W-1:0]     baud_cnt, baud_n;
   logic [3:0]            bit_cnt, bit_n;
   logic [DATA_WIDTH-1:0] shreg, sh_n;
   logic [DATA_WIDTH-1:0] checksum, ck_n;
   logic [ADDR_WIDTH-1:0] idx, idx_n;
   logic                  tx_q, tx_n;
   logic                  byte_end;
   logic [2:0]            bidx;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         checksum <= '0;
         idx      <= '0;
         tx_q     <= 1'b1;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_n;
         bit_cnt  <= bit_n;
         shreg    <= sh_n;
         checksum <= ck_n;
         idx      <= idx_n;
         tx_q     <= tx_n;
      end
   end

   always_comb begin
      state_n  = state;
      baud_n   = baud_cnt;
      bit_n    = bit_cnt;
      sh_n     = shreg;
      ck_n     = checksum;
      idx_n    = idx;
      byte_end = 1'b0;
      tx_n     = 1'b1;
      bidx     = '0;

      // Bit timing shared by the three transmitting states; bit_cnt 0 is the start
      // bit, 1..8 the data bits LSB first, 9 the stop bit.
      if (state inside {ST_HEADER, ST_SEND, ST_CHECKSUM}) begin
         if (baud_cnt == LAST_BAUD) begin
            baud_n = '0;
            if (bit_cnt == 4'd9) begin
               bit_n    = '0;
               byte_end = 1'b1;
            end else begin
               bit_n = bit_cnt + 4'd1;
            end
         end else begin
            baud_n = baud_cnt + 1'b1;
         end
      end

      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               state_n = ST_HEADER;
               idx_n   = '0;
               ck_n    = '0;
               sh_n    = HEADER;
               baud_n  = '0;
               bit_n   = '0;
            end
         end
         ST_HEADER: begin
            if (byte_end) state_n = ST_FETCH;
         end
         ST_FETCH: begin
            state_n = ST_WAIT_RD;
         end
         ST_WAIT_RD: begin
            sh_n    = bus.ram_data;
            ck_n    = checksum ^ bus.ram_data;
            baud_n  = '0;
            bit_n   = '0;
            state_n = ST_SEND;
         end
         ST_SEND: begin
            if (byte_end) begin
               if (idx == LAST_IDX) begin
                  state_n = ST_CHECKSUM;
                  sh_n    = checksum;
               end else begin
                  idx_n   = idx + 1'b1;
                  state_n = ST_FETCH;
               end
            end
         end
         ST_CHECKSUM: begin
            if (byte_end) state_n = ST_DONE;
         end
         ST_DONE: begin
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase

      // tx is registered from the next-state view so the line is glitch-free yet
      // lines up cycle-for-cycle with the state it belongs to.
      if (state_n inside {ST_HEADER, ST_SEND, ST_CHECKSUM}) begin
         bidx = 3'(bit_n - 4'd1);
         if (bit_n == 4'd0)      tx_n = 1'b0;
         else if (bit_n == 4'd9) tx_n = 1'b1;
         else                    tx_n = sh_n[bidx];
      end
   end

   // idx only advances on entry to FETCH, so the address is stable whenever no read is issued.
   assign bus.ram_rd_en = (state == ST_FETCH);
   assign bus.ram_addr  = idx;
   assign bus.tx        = tx_q;
   assign bus.busy      = (state != ST_IDLE) && (state != ST_DONE);
   assign bus.done      = (state == ST_DONE);

endmodule

// File: tb/tb_freq_bram_uart_reader.sv
// Randomised scoreboard bench for freq_bram_uart_reader: expected UART bytes, done
// cycles and BRAM reads are queued at start time and checked by decoupled monitors.
module tb_freq_bram_uart_reader;

   localparam int C    = 4;
   localparam int FB   = 16;
   localparam int AW   = 4;
   localparam int FB1  = 1;
   localparam int AW1  = 1;
   // Cycles from the start cycle through the done cycle, both inclusive.
   localparam int LAT  = 1 + (FB + 2) * 10 * C + 2 * FB + 1;
   localparam int LAT1 = 1 + (FB1 + 2) * 10 * C + 2 * FB1 + 1;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   freq_bram_uart_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(AW))  b ();
   freq_bram_uart_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(AW1)) b1 ();

   freq_bram_uart_reader #(
      .DATA_WIDTH(8), .FREQ_BINS(FB), .ADDR_WIDTH(AW), .CLKS_PER_BIT(C), .HEADER(8'hA5)
   ) dut (.clk(clk), .reset_n(reset_n), .bus(b.master));

   freq_bram_uart_reader #(
      .DATA_WIDTH(8), .FREQ_BINS(FB1), .ADDR_WIDTH(AW1), .CLKS_PER_BIT(C), .HEADER(8'hA5)
   ) dut1 (.clk(clk), .reset_n(reset_n), .bus(b1.master));

   // BRAM models: registered read, data valid the cycle after ram_rd_en.
   logic [7:0] ram  [FB];
   logic [7:0] ram1 [2];
   logic [7:0] rq, rq1;
   always @(posedge clk) begin
      if (b.ram_rd_en)  rq  <= ram[b.ram_addr];
      if (b1.ram_rd_en) rq1 <= ram1[b1.ram_addr];
   end
   assign b.ram_data  = rq;
   assign b1.ram_data = rq1;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   // Reference model: a frame occupies [cur_s, cur_d]; a start is taken only after it.
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   int         dq0[$];
   int         dq1[$];
   int         cur_s = -100;
   int         cur_d = -100;
   int         rd_exp = 0;
   logic       rd_prev = 1'b0;

   task automatic model0(input int t);
      logic [7:0] x;
      if (t > cur_d) begin
         cur_s = t;
         cur_d = t + LAT - 1;
         x = 8'h00;
         q0.push_back(8'hA5);
         for (int i = 0; i < FB; i++) begin
            q0.push_back(ram[i]);
            x = x ^ ram[i];
         end
         q0.push_back(x);
         dq0.push_back(cur_d);
         rd_exp = 0;
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start0();
      b.start = 1'b1;
      model0(cyc);
      @(posedge clk);
      #1 b.start = 1'b0;
   endtask

   function automatic logic txv(input int sel);
      return (sel != 0) ? b1.tx : b.tx;
   endfunction

   function automatic int qsize(input int sel);
      return (sel != 0) ? q1.size() : q0.size();
   endfunction

   function automatic logic [7:0] qpop(input int sel);
      if (sel != 0) return q1.pop_front();
      return q0.pop_front();
   endfunction

   // UART decoder: samples every cycle, demands each bit be held exactly C cycles.
   task automatic uart_mon(input int sel);
      logic       prev;
      logic [9:0] fr;
      logic       ok, ab;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            prev = 1'b1;
            continue;
         end
         if (txv(sel) == 1'b0 && prev == 1'b1) begin
            fr = '0;
            ok = 1'b1;
            ab = 1'b0;
            for (int bi = 0; bi < 10 && !ab; bi++) begin
               for (int k = 0; k < C && !ab; k++) begin
                  if (bi != 0 || k != 0) @(negedge clk);
                  if (!reset_n)      ab = 1'b1;
                  else if (k == 0)   fr[bi] = txv(sel);
                  else if (txv(sel) != fr[bi]) ok = 1'b0;
               end
            end
            if (!ab) begin
               chk("bit_hold", 32'(ok), 1);
               chk("start_bit", 32'(fr[0]), 0);
               chk("stop_bit", 32'(fr[9]), 1);
               if (qsize(sel) == 0) chk("byte_unexpected", 1, 0);
               else chk((sel != 0) ? "byte_fb1" : "byte", 32'(fr[8:1]), 32'(qpop(sel)));
            end
            prev = 1'b1;
         end else begin
            prev = txv(sel);
         end
      end
   endtask

   initial uart_mon(0);
   initial uart_mon(1);

   // Busy, done timing and BRAM read audit for the 16-bin instance.
   always @(negedge clk) begin
      if (reset_n) begin
         chk("busy", 32'(b.busy), 32'(cyc > cur_s && cyc < cur_d));
         if (b.done) begin
            if (dq0.size() == 0) chk("done_unexpected", 1, 0);
            else begin
               chk("done_cycle", cyc, dq0.pop_front());
               chk("frame_bytes_left", q0.size(), 0);
               chk("read_count", rd_exp, FB);
            end
         end
         if (b.ram_rd_en) begin
            chk("rd_addr", 32'(b.ram_addr), rd_exp);
            chk("rd_one_cycle", 32'(rd_prev), 0);
            rd_exp++;
         end
         rd_prev = b.ram_rd_en;
         if (b1.done) begin
            if (dq1.size() == 0) chk("done1_unexpected", 1, 0);
            else begin
               chk("done1_cycle", cyc, dq1.pop_front());
               chk("frame1_bytes_left", q1.size(), 0);
            end
         end
      end else begin
         rd_prev = 1'b0;
      end
   end

   initial begin
      b.start  = 1'b0;
      b1.start = 1'b0;
      for (int i = 0; i < FB; i++) ram[i] = 8'(i + 1);
      ram1[0] = 8'h3C;
      ram1[1] = 8'h00;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx", 32'(b.tx), 1);
      chk("rst_busy", 32'(b.busy), 0);
      chk("rst_done", 32'(b.done), 0);
      chk("rst_rd_en", 32'(b.ram_rd_en), 0);
      chk("rst_addr", 32'(b.ram_addr), 0);
      reset_n = 1'b1;
      wait_cyc(2);

      // Ramp frame on the main instance alongside a single-bin frame: A5,3C,3C.
      b.start  = 1'b1;
      b1.start = 1'b1;
      model0(cyc);
      q1.push_back(8'hA5);
      q1.push_back(8'h3C);
      q1.push_back(8'h3C);
      dq1.push_back(cyc + LAT1 - 1);
      @(posedge clk);
      #1;
      b.start  = 1'b0;
      b1.start = 1'b0;
      wait_cyc(LAT + 5);

      for (int i = 0; i < FB; i++) ram[i] = 8'hFF;
      start0();
      wait_cyc(LAT + 5);
      for (int i = 0; i < FB; i++) ram[i] = 8'h00;
      start0();
      wait_cyc(LAT + 5);

      repeat (3) begin
         for (int i = 0; i < FB; i++) ram[i] = 8'($urandom);
         start0();
         wait_cyc(LAT + 5);
      end

      // Starts every 50 cycles while busy, then start held across DONE and IDLE.
      for (int i = 0; i < FB; i++) ram[i] = 8'($urandom);
      start0();
      repeat (14) begin
         wait_cyc(49);
         start0();
      end
      wait_cyc(cur_d - cyc);
      b.start = 1'b1;
      model0(cyc);
      @(posedge clk);
      #1;
      model0(cyc);
      @(posedge clk);
      #1 b.start = 1'b0;
      wait_cyc(LAT + 5);

      // Reset during the start bit of bin 5 (value 6, so tx is low before reset).
      for (int i = 0; i < FB; i++) ram[i] = 8'(i + 1);
      start0();
      wait_cyc(253);
      @(posedge clk);
      #2;
      chk("pre_rst_tx", 32'(b.tx), 0);
      chk("pre_rst_busy", 32'(b.busy), 1);
      reset_n = 1'b0;
      #1;
      chk("midrst_tx", 32'(b.tx), 1);
      chk("midrst_busy", 32'(b.busy), 0);
      chk("midrst_rd_en", 32'(b.ram_rd_en), 0);
      q0.delete();
      dq0.delete();
      cur_s  = -100;
      cur_d  = -100;
      rd_exp = 0;
      wait_cyc(3);
      reset_n = 1'b1;
      wait_cyc(2);
      start0();
      wait_cyc(LAT + 5);

      chk("pending_bytes", q0.size() + q1.size(), 0);
      chk("pending_done", dq0.size() + dq1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
